// File: rtl/mem_if16b.sv
// Memory-side bus interface: sequences CS/OE/WE onto an external asynchronous memory.
// Define MEMIF_TIMEOUT_EN to abort an ACCESS that sees no mem_ack within TIMEOUT cycles.
module mem_if16b #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        busy,
  output logic [15:0] mem_addr,
  inout  wire  [15:0] mem_data,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic        mem_ack
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_if16b: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

`ifdef MEMIF_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  localparam logic [7:0] TO_M1  = 8'(TIMEOUT - 1);

  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEMIF_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = SETUP;
`ifdef MEMIF_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_data;
          state_d = HOLD;
        end else begin
`ifdef MEMIF_TIMEOUT_EN
          // The current ACCESS cycle is number cnt_q+1; the last allowed one aborts.
          if (cnt_q == TO_M1) begin
            err_d   = 1'b1;
            state_d = HOLD;
          end
          if (cnt_q != TO_LIM) cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      HOLD: begin
        state_d = IDLE;
`ifdef MEMIF_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      rdata_q <= 16'h0000;
`ifdef MEMIF_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
`ifdef MEMIF_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Write data is only observable while a write is in flight, so it needs no reset.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  assign busy      = (state_q != IDLE);
  assign mem_cs    = busy;
  assign mem_oe    = (state_q == ACCESS) && !we_q;
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign cpu_done  = (state_q == HOLD);
  assign mem_addr  = addr_q;
  assign cpu_rdata = rdata_q;
  assign mem_data  = (busy && we_q) ? wdata_q : 16'hzzzz;

`ifdef MEMIF_TIMEOUT_EN
  assign cpu_err = err_q;
`else
  assign cpu_err = 1'b0;
`endif

endmodule
